player_motion_ctrl: RTL and testbench
=====================================

// Module: player_motion_ctrl
// PURPOSE
//  Sequences the player sprite position from the key2state move_state code.
//  Generates its own step tick and applies one pixel of motion per tick.
//  Runs a ground/rise/fall jump state machine and clamps (or wraps) at screen edges.
//  Drives posX/posY of the color renderer; sits between key2state and color.
// PARAMETERS
//  TICK_DIV  262144  clk cycles per motion step (>=2)
//  X_MAX     640     right-most legal posx (<=1023)
//  Y_MAX     480     bottom-most legal posy (<=511)
//  X_INIT    320     posx after reset
//  Y_INIT    400     posy after reset (<=Y_MAX)
//  JUMP_H    32      jump apex height in pixels (1..255)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-high
//  move_state  in   4   [3]=jump, [2:0]: 0 stop, 1 up, 2 left, 3 right, 4 down, 5-7 stop
//  posx        out  10  sprite x, registered
//  posy        out  9   sprite y, registered (0 = top)
//  airborne    out  1   1 while state != GROUND, registered
//  step_tick   out  1   one-clk pulse marking each motion step
// BEHAVIOUR
//  - Reset (async, immediate): posx=X_INIT, posy=Y_INIT, airborne=0, step_tick=0,
//    state=GROUND, tick counter=0, jump_cnt=0, base_y=Y_INIT. Reset mid-jump aborts the jump.
//  - Tick counter 0..TICK_DIV-1. step_tick=1 for the cycle the counter equals TICK_DIV-1;
//    the counter then returns to 0. First pulse at cycle TICK_DIV-1 after reset release.
//  - move_state is sampled only in the step_tick cycle. Updates land on the next clk edge.
//  - Horizontal (every state): left -> posx-1, right -> posx+1; edge rule below.
//  - GROUND: if move_state[3]=1 and posy!=0 -> RISE, base_y<=posy, posy<=posy-1, jump_cnt<=1.
//    Else up -> posy-1, down -> posy+1 (edge rule). Jump beats up/down in the same tick.
//    A jump request with posy==0 is ignored; up/down then apply normally.
//  - RISE: if jump_cnt<JUMP_H and posy!=0 -> posy-1, jump_cnt+1;
//    else -> FALL, posy+1. Up/down/jump ignored.
//  - FALL: posy+1; if posy+1==base_y -> GROUND. Jump ignored (no double jump).
//  - Apex = base_y-JUMP_H (or 0 if lower). A full jump lasts 2*JUMP_H ticks.
//  - airborne is set and cleared on the same edge as the state change.
//    It falls on the edge where posy returns to base_y.
//  - Widths: arithmetic is unsigned at port width; comparisons occur before the +/-1
//    so no intermediate value underflows.
// CONFIGURATION
//  WRAP_EN defined: ground/horizontal edges wrap: left at 0 -> X_MAX, right at X_MAX -> 0,
//    up at 0 -> Y_MAX, down at Y_MAX -> 0. Jump vertical motion never wraps.
//  WRAP_EN undefined (default): saturate: posx in [0,X_MAX], posy in [0,Y_MAX];
//    a move past an edge leaves the coordinate unchanged.
// TESTING (bench uses TICK_DIV=4, defaults otherwise)
//  1. rst pulse, move_state=4'h3 for 3 ticks -> posx 320->321->322->323;
//     step_tick exactly every 4th clk.
//  2. Drive posx to 0 with left, hold left 2 more ticks -> posx stays 0;
//     with WRAP_EN -> posx=640, then 639.
//  3. move_state=4'h8 one tick at posy=400 -> airborne=1, posy 399..368 over ticks 1-32,
//     369 at tick 33, 400 at tick 64, airborne=0 on that same edge.
//  4. move_state=4'hB at posx=100/posy=400 -> same edge: posx=101, posy=399, airborne=1;
//     at tick 2 with 4'h1 -> posy=398 (up ignored).
//  5. Jump from posy=10 -> posy reaches 0 at tick 10, 1 at tick 11,
//     lands posy=10 at tick 20, airborne=0.
//  6. Assert rst mid-jump (posy=380) -> same cycle posx=320, posy=400, airborne=0,
//     step_tick=0; next pulse TICK_DIV-1 cycles after release.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// Player sprite motion sequencer: self-timed step tick, 1 px per step, ground/rise/fall jump FSM.
// Screen edges saturate by default; define WRAP_EN to wrap ground/horizontal motion at the edges.
module player_motion_ctrl #(
  parameter int TICK_DIV = 262144,
  parameter int X_MAX    = 640,
  parameter int Y_MAX    = 480,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 400,
  parameter int JUMP_H   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] move_state,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       airborne,
  output logic       step_tick
);

  localparam int              CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [9:0]      XM        = 10'(X_MAX);
  localparam logic [8:0]      YM        = 9'(Y_MAX);
  localparam logic [7:0]      JH        = 8'(JUMP_H);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    posx_q, posx_d;
  logic [8:0]    posy_q, posy_d;
  logic [8:0]    base_y_q, base_y_d;
  logic [7:0]    jump_cnt_q, jump_cnt_d;
  logic          airborne_q, airborne_d;
  logic          tick;
  logic [2:0]    dir;

  assign tick = (cnt_q == TICK_LAST);
  assign dir  = move_state[2:0];

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    state_d    = state_q;
    posx_d     = posx_q;
    posy_d     = posy_q;
    base_y_d   = base_y_q;
    jump_cnt_d = jump_cnt_q;

    if (tick) begin
      // Horizontal motion is independent of the jump state.
      if (dir == 3'd2) begin
        if (posx_q != 10'd0) posx_d = posx_q - 10'd1;
`ifdef WRAP_EN
        else                 posx_d = XM;
`endif
      end else if (dir == 3'd3) begin
        if (posx_q < XM) posx_d = posx_q + 10'd1;
`ifdef WRAP_EN
        else             posx_d = 10'd0;
`endif
      end

      case (state_q)
        GROUND: begin
          if (move_state[3] && posy_q != 9'd0) begin
            state_d    = RISE;
            base_y_d   = posy_q;
            posy_d     = posy_q - 9'd1;
            jump_cnt_d = 8'd1;
          end else if (dir == 3'd1) begin
            if (posy_q != 9'd0) posy_d = posy_q - 9'd1;
`ifdef WRAP_EN
            else                posy_d = YM;
`endif
          end else if (dir == 3'd4) begin
            if (posy_q < YM) posy_d = posy_q + 9'd1;
`ifdef WRAP_EN
            else             posy_d = 9'd0;
`endif
          end
        end
        RISE: begin
          if (jump_cnt_q < JH && posy_q != 9'd0) begin
            posy_d     = posy_q - 9'd1;
            jump_cnt_d = jump_cnt_q + 8'd1;
          end else begin
            // A one-pixel jump lands on the very first descending step.
            posy_d  = posy_q + 9'd1;
            state_d = (posy_q + 9'd1 == base_y_q) ? GROUND : FALL;
          end
        end
        FALL: begin
          posy_d = posy_q + 9'd1;
          if (posy_q + 9'd1 == base_y_q) state_d = GROUND;
        end
        default: state_d = GROUND;
      endcase
    end

    airborne_d = (state_d != GROUND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GROUND;
      cnt_q      <= '0;
      posx_q     <= 10'(X_INIT);
      posy_q     <= 9'(Y_INIT);
      base_y_q   <= 9'(Y_INIT);
      jump_cnt_q <= 8'd0;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
      base_y_q   <= base_y_d;
      jump_cnt_q <= jump_cnt_d;
      airborne_q <= airborne_d;
    end
  end

  assign posx      = posx_q;
  assign posy      = posy_q;
  assign airborne  = airborne_q;
  assign step_tick = tick;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus random moves against a trajectory-queue model.
module tb_player_motion_ctrl;

  localparam int TD     = 4;
  localparam int X_MAX  = 640;
  localparam int Y_MAX  = 480;
  localparam int X_INIT = 320;
  localparam int Y_INIT = 400;
  localparam int JUMP_H = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] move_state = 4'h0;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       airborne;
  logic       step_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int mx, my, cyc;
  bit mair;
  int traj[$];

  player_motion_ctrl #(
    .TICK_DIV(TD), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .JUMP_H(JUMP_H)
  ) dut (
    .clk(clk), .rst(rst), .move_state(move_state),
    .posx(posx), .posy(posy), .airborne(airborne), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = X_INIT; my = Y_INIT; mair = 0; cyc = 0;
    traj.delete();
  endtask

  // One motion step: jumps are a precomputed list of y positions to replay.
  task automatic model_step(input logic [3:0] ms);
    int h;
    if (ms[2:0] == 3'd2) begin
      if (mx > 0) mx--;
`ifdef WRAP_EN
      else mx = X_MAX;
`endif
    end else if (ms[2:0] == 3'd3) begin
      if (mx < X_MAX) mx++;
`ifdef WRAP_EN
      else mx = 0;
`endif
    end
    if (traj.size() > 0) begin
      my = traj.pop_front();
    end else if (ms[3] && my != 0) begin
      h = (my < JUMP_H) ? my : JUMP_H;
      for (int i = 1; i <= h; i++) traj.push_back(my - i);
      for (int i = h - 1; i >= 0; i--) traj.push_back(my - i);
      my = traj.pop_front();
    end else if (ms[2:0] == 3'd1) begin
      if (my > 0) my--;
`ifdef WRAP_EN
      else my = Y_MAX;
`endif
    end else if (ms[2:0] == 3'd4) begin
      if (my < Y_MAX) my++;
`ifdef WRAP_EN
      else my = 0;
`endif
    end
    mair = (traj.size() > 0);
  endtask

  // Called at a negedge: drive, check tick, advance one clock, check position.
  task automatic cycle(input logic [3:0] ms);
    bit exp_tick;
    move_state = ms;
    exp_tick = ((cyc % TD) == TD - 1);
    check("step_tick", int'(step_tick), int'(exp_tick));
    if (exp_tick) model_step(ms);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("posx", int'(posx), mx);
    check("posy", int'(posy), my);
    check("airborne", int'(airborne), int'(mair));
  endtask

  task automatic ticks(input logic [3:0] ms, input int n);
    repeat (n * TD) cycle(ms);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_posx", int'(posx), X_INIT);
    check("rst_posy", int'(posy), Y_INIT);
    check("rst_airborne", int'(airborne), 0);
    check("rst_step_tick", int'(step_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("init_posx", int'(posx), X_INIT);
    check("init_posy", int'(posy), Y_INIT);
    check("init_airborne", int'(airborne), 0);
    check("init_step_tick", int'(step_tick), 0);
    rst = 1'b0;

    // 1: three right steps
    ticks(4'h3, 3);
    check("t1_posx", int'(posx), 323);

    // 2: left to the edge, then two more
    ticks(4'h2, 323);
    check("t2_posx_edge", int'(posx), 0);
    ticks(4'h2, 2);
`ifdef WRAP_EN
    check("t2_posx_wrap", int'(posx), 639);
`else
    check("t2_posx_sat", int'(posx), 0);
`endif

    // 3: full jump from 400
    ticks(4'h8, 1);
    check("t3_air", int'(airborne), 1);
    check("t3_y1", int'(posy), 399);
    ticks(4'h0, 31);
    check("t3_apex", int'(posy), 368);
    ticks(4'h0, 1);
    check("t3_y33", int'(posy), 369);
    ticks(4'h0, 30);
    check("t3_air63", int'(airborne), 1);
    ticks(4'h0, 1);
    check("t3_land", int'(posy), 400);
    check("t3_air_clr", int'(airborne), 0);

    // 4: jump combined with right move
    do_reset();
    ticks(4'h2, 220);
    check("t4_posx", int'(posx), 100);
    ticks(4'hB, 1);
    check("t4_posx_r", int'(posx), 101);
    check("t4_posy", int'(posy), 399);
    check("t4_air", int'(airborne), 1);
    ticks(4'h1, 1);
    check("t4_up_ignored", int'(posy), 398);
    ticks(4'h0, 62);
    check("t4_land", int'(posy), 400);

    // 5: jump clipped by top edge
    ticks(4'h1, 390);
    check("t5_start", int'(posy), 10);
    ticks(4'h8, 1);
    ticks(4'h0, 9);
    check("t5_top", int'(posy), 0);
    ticks(4'h0, 1);
    check("t5_y11", int'(posy), 1);
    ticks(4'h0, 9);
    check("t5_land", int'(posy), 10);
    check("t5_air_clr", int'(airborne), 0);

    // 6: reset mid-jump
    do_reset();
    ticks(4'h8, 1);
    ticks(4'h0, 19);
    check("t6_midjump", int'(posy), 380);
    do_reset();
    ticks(4'h0, 2);

    // random moves, with edges reached through long runs
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] ms;
      ms = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) ticks(ms, $urandom_range(1, 40));
      else ticks(ms, 1);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
